field_lock_clear: RTL and testbench

FIELD_LOCK_CLEAR -- requirements
Module: field_lock_clear

---
 rtl/field_lock_clear.sv | 139 +++++++++++++
 tb/tb_field_lock_clear.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_lock_clear.sv
// Playfield lock/line-clear engine: merges a latched 3x3 piece into a 10x10
// field, then removes full rows one scan step at a time, bottom row first.
module field_lock_clear (
  input  logic        clock,
  input  logic        resetn,
  input  logic        lock_req,
  input  logic        clear_req,
  input  logic [0:8]  block,
  input  logic [3:0]  blockX,
  input  logic [3:0]  blockY,
  output logic [0:99] field,
  output logic        busy,
  output logic        done,
  output logic [1:0]  lines_cleared,
  output logic [15:0] total_lines,
  output logic        game_over
);

  typedef enum logic [2:0] {IDLE, MERGE, SCAN, SHIFT, DONE} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_row;
  logic [1:0]  r_count;
  logic [0:8]  r_block;
  logic [3:0]  r_bx, r_by;
  logic [0:99] r_field;
  logic [1:0]  r_lines;
  logic [15:0] r_total;
  logic        r_go;

  logic [0:99] w_merged, w_shifted;
  logic [15:0] w_full;
  logic        w_row_full;
  logic [16:0] w_sum;

  // Each in-field cell is set when some mask bit lands on it; anything
  // landing past row/col 9 simply matches no cell and is dropped.
  always_comb begin
    w_merged = r_field;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        for (int y = 0; y < 3; y++)
          for (int x = 0; x < 3; x++)
            if (r >= y && c >= x && r_block[y*3+x] &&
                r_by == 4'(r - y) && r_bx == 4'(c - x))
              w_merged[r*10+c] = 1'b1;
  end

  always_comb begin
    w_full = '0;
    for (int r = 0; r < 10; r++)
      w_full[r] = &r_field[r*10 +: 10];
    w_row_full = w_full[r_row];
  end

  always_comb begin
    w_shifted = r_field;
    for (int r = 1; r < 10; r++)
      if (4'(r) <= r_row)
        w_shifted[r*10 +: 10] = r_field[(r-1)*10 +: 10];
    w_shifted[0:9] = '0;
  end

  assign w_sum = {1'b0, r_total} + {15'd0, r_count};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (lock_req && !clear_req) w_next = MERGE;
      MERGE:   w_next = SCAN;
      SCAN: begin
        if (w_row_full)          w_next = SHIFT;
        else if (r_row == 4'd0)  w_next = DONE;
      end
      SHIFT:   w_next = SCAN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_row   <= 4'd9;
      r_count <= 2'd0;
      r_block <= '0;
      r_bx    <= 4'd0;
      r_by    <= 4'd0;
      r_field <= '0;
      r_lines <= 2'd0;
      r_total <= 16'd0;
      r_go    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (clear_req) begin
            r_field <= '0;
            r_lines <= 2'd0;
            r_total <= 16'd0;
            r_go    <= 1'b0;
          end else if (lock_req) begin
            r_block <= block;
            r_bx    <= blockX;
            r_by    <= blockY;
          end
        end
        MERGE: begin
          r_field <= w_merged;
          r_row   <= 4'd9;
          r_count <= 2'd0;
        end
        SCAN: begin
          // Pointer stays put on a full row so the row shifted down gets rescanned.
          if (!w_row_full && r_row != 4'd0) r_row <= r_row - 4'd1;
        end
        SHIFT: begin
          r_field <= w_shifted;
          if (r_count != 2'd3) r_count <= r_count + 2'd1;
        end
        DONE: begin
          r_lines <= r_count;
          r_total <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
          r_go    <= r_go | (|r_field[0:9]);
          r_row   <= 4'd9;
        end
        default: ;
      endcase
    end
  end

  assign field         = r_field;
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);
  assign lines_cleared = r_lines;
  assign total_lines   = r_total;
  assign game_over     = r_go;

endmodule

// File: tb/tb_field_lock_clear.sv
// Scoreboard bench for field_lock_clear: the driver queues the expected
// completion of every lock, a monitor pops and compares on each done pulse.
module tb_field_lock_clear;

  logic        clock = 1'b0;
  logic        resetn, lock_req, clear_req;
  logic [0:8]  block;
  logic [3:0]  blockX, blockY;
  logic [0:99] field;
  logic        busy, done, game_over;
  logic [1:0]  lines_cleared;
  logic [15:0] total_lines;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [0:99] fld;
    logic [1:0]  lines;
    logic [15:0] total;
    logic        go;
    int          done_cyc;
  } exp_t;

  exp_t sbq[$];

  logic [0:99] m_field;
  logic [15:0] m_total;
  logic        m_go;

  field_lock_clear dut (
    .clock(clock), .resetn(resetn), .lock_req(lock_req), .clear_req(clear_req),
    .block(block), .blockX(blockX), .blockY(blockY), .field(field),
    .busy(busy), .done(done), .lines_cleared(lines_cleared),
    .total_lines(total_lines), .game_over(game_over)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [0:99] model_place(input logic [0:99] f, input logic [0:8] b,
                                              input int x, input int y);
    logic [0:99] g;
    g = f;
    for (int yy = 0; yy < 3; yy++)
      for (int xx = 0; xx < 3; xx++)
        if (b[yy*3+xx] && (y + yy) <= 9 && (x + xx) <= 9)
          g[(y+yy)*10 + x + xx] = 1'b1;
    return g;
  endfunction

  // Reference removal: keep non-full rows, packed to the bottom in order.
  function automatic logic [0:99] model_compact(input logic [0:99] f);
    logic [0:99] g;
    int dst;
    g = '0;
    dst = 9;
    for (int src = 9; src >= 0; src--)
      if (f[src*10 +: 10] != 10'h3FF) begin
        g[dst*10 +: 10] = f[src*10 +: 10];
        dst--;
      end
    return g;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("idle_reached", 128'(busy), 128'(0));
  endtask

  // Called at a falling edge; k is the hand-counted number of rows this lock clears.
  task automatic do_lock(input logic [0:8] b, input int x, input int y, input int k,
                         input bit wait_done);
    exp_t e;
    int   t;
    lock_req  = 1'b1;
    clear_req = 1'b0;
    block     = b;
    blockX    = 4'(x);
    blockY    = 4'(y);
    m_field = model_compact(model_place(m_field, b, x, y));
    t = int'(m_total) + k;
    m_total = (t > 65535) ? 16'hFFFF : 16'(t);
    m_go = m_go | (|m_field[0:9]);
    e.fld = m_field;
    e.lines = 2'(k);
    e.total = m_total;
    e.go = m_go;
    e.done_cyc = cyc + 12 + 2*k;
    sbq.push_back(e);
    @(posedge clock);
    @(negedge clock);
    lock_req = 1'b0;
    block    = ~b;
    blockX   = ~4'(x);
    blockY   = ~4'(y);
    if (wait_done) wait_idle();
  endtask

  task automatic do_clear(input bit with_lock);
    clear_req = 1'b1;
    lock_req  = with_lock;
    block     = 9'h1FF;
    blockX    = 4'd0;
    blockY    = 4'd9;
    @(posedge clock);
    @(negedge clock);
    clear_req = 1'b0;
    lock_req  = 1'b0;
    m_field = '0;
    m_total = 16'd0;
    m_go    = 1'b0;
    chk("clr_field", 128'(field), 128'(0));
    chk("clr_busy", 128'(busy), 128'(0));
    chk("clr_total", 128'(total_lines), 128'(0));
    chk("clr_lines", 128'(lines_cleared), 128'(0));
    chk("clr_game_over", 128'(game_over), 128'(0));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_field"}, 128'(field), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_lines"}, 128'(lines_cleared), 128'(0));
    chk({tag, "_total"}, 128'(total_lines), 128'(0));
    chk({tag, "_game_over"}, 128'(game_over), 128'(0));
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_done: actual=done high required=no lock pending (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_latency", 128'(cyc), 128'(e.done_cyc));
          chk("done_field", 128'(field), 128'(e.fld));
          @(negedge clock);
          chk("done_one_cycle", 128'(done), 128'(0));
          chk("lines_cleared", 128'(lines_cleared), 128'(e.lines));
          chk("total_lines", 128'(total_lines), 128'(e.total));
          chk("game_over", 128'(game_over), 128'(e.go));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    resetn = 1'b0; lock_req = 1'b0; clear_req = 1'b0;
    block = '0; blockX = 4'd0; blockY = 4'd0;
    m_field = '0; m_total = 16'd0; m_go = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset("rst");
    resetn = 1'b1;

    // Single bar on the bottom row.
    do_lock(9'b111_000_000, 0, 9, 0, 1'b1);
    chk("t1_row9", 128'(field[90:99]), 128'(10'b1110000000));

    // Complete row 9 with the last cell -> one line.
    do_lock(9'b111_000_000, 3, 9, 0, 1'b1);
    do_lock(9'b111_000_000, 6, 9, 0, 1'b1);
    do_lock(9'b100_000_000, 9, 9, 1, 1'b1);
    chk("t2_field", 128'(field), 128'(0));
    chk("t2_total", 128'(total_lines), 128'(1));

    // Triple clear, row 6 content drops into row 9.
    do_lock(9'b111_111_111, 1, 7, 0, 1'b1);
    do_lock(9'b111_111_111, 4, 7, 0, 1'b1);
    do_lock(9'b111_111_111, 7, 7, 0, 1'b1);
    do_lock(9'b100_000_000, 9, 6, 0, 1'b1);
    do_lock(9'b100_100_100, 0, 7, 3, 1'b1);
    chk("t3_row9", 128'(field[90:99]), 128'(10'b0000000001));
    chk("t3_total", 128'(total_lines), 128'(4));

    // Off-field discard and game_over.
    do_clear(1'b0);
    do_lock(9'b100_100_100, 4, 7, 0, 1'b1);
    do_lock(9'b100_100_100, 4, 4, 0, 1'b1);
    do_lock(9'b100_100_100, 4, 1, 0, 1'b1);
    do_lock(9'b000_000_010, 3, 15, 0, 1'b1);
    chk("t4_discard_col4", 128'(field), 128'(m_field));
    do_lock(9'b111_000_000, 8, 9, 0, 1'b1);
    chk("t4_col_clip", 128'(field[90:99]), 128'(10'b0000100011));
    do_lock(9'b010_000_000, 3, 0, 0, 1'b1);
    do_lock(9'b100_000_000, 0, 9, 0, 1'b1);
    chk("t4_still_over", 128'(game_over), 128'(1));
    do_clear(1'b0);

    // Reset in the middle of a SHIFT.
    do_lock(9'b111_000_000, 0, 9, 0, 1'b1);
    do_lock(9'b111_000_000, 3, 9, 0, 1'b1);
    do_lock(9'b111_000_000, 6, 9, 0, 1'b1);
    do_lock(9'b100_000_000, 9, 9, 1, 1'b1);
    do_lock(9'b111_000_000, 0, 9, 0, 1'b1);
    do_lock(9'b111_000_000, 3, 9, 0, 1'b1);
    do_lock(9'b111_000_000, 6, 9, 0, 1'b1);
    do_lock(9'b100_000_000, 9, 9, 1, 1'b0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("t5_in_shift_busy", 128'(busy), 128'(1));
    sbq.delete();
    resetn = 1'b0;
    #1;
    chk_reset("mid_rst");
    m_field = '0; m_total = 16'd0; m_go = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    do_lock(9'b111_000_000, 0, 9, 0, 1'b1);

    // Requests and input changes while busy are ignored.
    do_lock(9'b100_000_000, 5, 5, 0, 1'b0);
    @(negedge clock);
    lock_req = 1'b1; clear_req = 1'b1;
    block = 9'h1FF; blockX = 4'd0; blockY = 4'd0;
    @(negedge clock);
    lock_req = 1'b0; clear_req = 1'b0;
    wait_idle();
    repeat (20) @(negedge clock);
    chk("busy_pulse_field", 128'(field), 128'(m_field));

    // Lock and clear together in IDLE: clear wins.
    do_clear(1'b1);
    repeat (20) @(negedge clock);
    chk("both_busy_late", 128'(busy), 128'(0));
    chk("both_field_late", 128'(field), 128'(0));

    // Saturation of the running total.
    dut.r_total = 16'hFFFE;
    m_total = 16'hFFFE;
    do_lock(9'b111_111_000, 0, 8, 0, 1'b1);
    do_lock(9'b111_111_000, 3, 8, 0, 1'b1);
    do_lock(9'b111_111_000, 6, 8, 0, 1'b1);
    do_lock(9'b100_100_000, 9, 8, 2, 1'b1);
    chk("sat_total", 128'(total_lines), 128'(16'hFFFF));
    do_lock(9'b111_000_000, 0, 9, 0, 1'b1);
    do_lock(9'b111_000_000, 3, 9, 0, 1'b1);
    do_lock(9'b111_000_000, 6, 9, 0, 1'b1);
    do_lock(9'b100_000_000, 9, 9, 1, 1'b1);
    chk("sat_hold", 128'(total_lines), 128'(16'hFFFF));

    repeat (5) @(negedge clock);
    chk("sbq_drained", 128'(sbq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
